// File: rtl/mem_bist.sv
// March-style built-in self-test for a 2^AW x DW synchronous single-port memory.
// Four phases run back to back: write P0, read/compare P0, write P1 = ~P0,
// read/compare P1. P0(a) = seed_q ^ a, so every word differs from its
// neighbours and the inverted phase exercises every bit in both polarities.
//
// Handshake: start is a level sampled only while idle; the edge that sees
// start=1 in IDLE accepts it and captures seed. start at any other time is
// ignored (no restart, no queueing). done is a one-cycle pulse that marks
// the end of a test; pass/err_cnt/fail_addr stay valid until the next accept.
module mem_bist #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [DW-1:0] seed,
  output logic          cen,
  output logic          wen,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] din,
  input  logic [DW-1:0] dout,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [6:0]    err_cnt,
  output logic [AW-1:0] fail_addr
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR0  = 3'd1,
    RD0  = 3'd2,
    WR1  = 3'd3,
    RD1  = 3'd4,
    FIN  = 3'd5
  } state_t;

  // state is kept as a named enum so checkers can bind to it directly
  state_t        state;
  state_t        state_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] din_d;
  logic [DW-1:0] seed_q;
  logic [DW-1:0] seed_d;
  logic [DW-1:0] exp_data;
  logic          accept;
  logic          last_addr;
  logic          mismatch;
  logic          first_fail;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state, next address and next write data
  always_comb begin
    state_d   = state;
    addr_d    = '0;
    din_d     = '0;
    accept    = (state == IDLE) && start;
    last_addr = (addr == {AW{1'b1}});
    // the seed is not registered yet on the accepting edge, so use the input
    seed_d    = accept ? seed : seed_q;

    case (state)
      IDLE: if (start) state_d = WR0;
      WR0:  if (last_addr) state_d = RD0;
      RD0:  if (last_addr) state_d = WR1;
      WR1:  if (last_addr) state_d = RD1;
      RD1:  if (last_addr) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // walk the address inside a phase; wrap to 0 when moving on
    if ((state == WR0 || state == RD0 || state == WR1 || state == RD1) && !last_addr) begin
      addr_d = addr + 1'b1;
    end

    if (state_d == WR0) begin
      din_d = seed_d ^ {{(DW-AW){1'b0}}, addr_d};
    end else if (state_d == WR1) begin
      din_d = ~(seed_d ^ {{(DW-AW){1'b0}}, addr_d});
    end
  end

  // Expected read data for the current address and read phase
  always_comb begin
    exp_data = seed_q ^ {{(DW-AW){1'b0}}, addr};
    if (state == RD1) begin
      exp_data = ~exp_data;
    end
    mismatch = ((state == RD0) || (state == RD1)) && (dout != exp_data);
  end

  // Registered memory port, status and result tracking
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cen        <= 1'b0;
      wen        <= 1'b0;
      addr       <= '0;
      din        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_addr  <= '0;
      first_fail <= 1'b0;
      seed_q     <= '0;
    end else begin
      cen  <= (state_d == WR0) || (state_d == RD0) || (state_d == WR1) || (state_d == RD1);
      wen  <= (state_d == WR0) || (state_d == WR1);
      addr <= addr_d;
      din  <= din_d;
      busy <= (state_d != IDLE);
      done <= (state == FIN);

      if (accept) begin
        seed_q     <= seed;
        err_cnt    <= '0;
        fail_addr  <= '0;
        pass       <= 1'b0;
        first_fail <= 1'b0;
      end

      // at most 64 compares per test, so the 7-bit count cannot wrap
      if (mismatch) begin
        err_cnt <= err_cnt + 7'd1;
        if (!first_fail) begin
          fail_addr  <= addr;
          first_fail <= 1'b1;
        end
      end

      if (state == FIN) begin
        pass <= (err_cnt == 7'd0);
      end
    end
  end

endmodule

// File: tb/tb_mem_bist.sv
// Directed bench for mem_bist with a behavioural single-port memory that can
// be switched between ideal, word-5-bit-3-stuck-at-0 and addr[4]-ignored.
module tb_mem_bist;

  localparam int AW = 5;
  localparam int DW = 32;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [DW-1:0] seed = '0;
  logic          cen;
  logic          wen;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          busy;
  logic          done;
  logic          pass;
  logic [6:0]    err_cnt;
  logic [AW-1:0] fail_addr;

  mem_bist #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .seed      (seed),
    .cen       (cen),
    .wen       (wen),
    .addr      (addr),
    .din       (din),
    .dout      (dout),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_cnt   (err_cnt),
    .fail_addr (fail_addr)
  );

  // memory model: 0 = ideal, 1 = word 5 bit 3 stuck at 0, 2 = addr[4] ignored
  int            mem_mode = 0;
  logic [DW-1:0] mem [32];
  logic [AW-1:0] mem_idx;
  logic [DW-1:0] rd_word;

  always_comb begin
    mem_idx = (mem_mode == 2) ? {1'b0, addr[3:0]} : addr;
    rd_word = mem[mem_idx];
    if (mem_mode == 1 && addr == 5'd5) rd_word[3] = 1'b0;
    dout = (cen && !wen) ? rd_word : '0;
  end

  always @(posedge clk) begin
    if (cen && wen) mem[mem_idx] <= din;
  end

  // scoreboard counters
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: called #1 after an edge; the next edge is edge 0 of the run
  task automatic start_pulse(input logic [DW-1:0] s);
    start = 1'b1;
    seed  = s;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // waits for done after edge 0, recording a few write-data samples
  task automatic wait_done(input bit repulse, output int lat, output int n_done,
                           output logic [DW-1:0] d0_5, output logic [DW-1:0] d1_5,
                           output logic [DW-1:0] d1_0);
    lat = 300;
    n_done = 0;
    d0_5 = '0;
    d1_5 = '0;
    d1_0 = '0;
    for (int n = 1; n <= 300; n++) begin
      start = repulse && (n == 40 || n == 129);
      @(posedge clk);
      #1;
      if (cen && wen && addr == 5'd5 && n <= 32) d0_5 = din;
      if (cen && wen && addr == 5'd5 && n > 32) d1_5 = din;
      if (cen && wen && addr == 5'd0 && n > 32) d1_0 = din;
      if (n == 128) begin
        check("fin_cen", {31'd0, cen}, 32'd0);
        check("fin_busy", {31'd0, busy}, 32'd1);
      end
      if (done) begin
        n_done++;
        lat = n;
        break;
      end
    end
  endtask

  int            lat;
  int            n_done;
  logic [DW-1:0] d0_5;
  logic [DW-1:0] d1_5;
  logic [DW-1:0] d1_0;

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cen", {31'd0, cen}, 32'd0);
    check("rst_wen", {31'd0, wen}, 32'd0);
    check("rst_addr", {27'd0, addr}, 32'd0);
    check("rst_din", din, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    check("rst_err", {25'd0, err_cnt}, 32'd0);
    check("rst_faddr", {27'd0, fail_addr}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // ideal memory
    mem_mode = 0;
    start_pulse(32'hA5A5_0000);
    check("t1_cen0", {31'd0, cen}, 32'd1);
    check("t1_wen0", {31'd0, wen}, 32'd1);
    check("t1_din0", din, 32'hA5A5_0000);
    check("t1_busy0", {31'd0, busy}, 32'd1);
    wait_done(1'b0, lat, n_done, d0_5, d1_5, d1_0);
    check("t1_lat", lat, 129);
    check("t1_wr0_5", d0_5, 32'hA5A5_0005);
    check("t1_wr1_5", d1_5, 32'h5A5A_FFFA);
    check("t1_pass", {31'd0, pass}, 32'd1);
    check("t1_err", {25'd0, err_cnt}, 32'd0);
    check("t1_faddr", {27'd0, fail_addr}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check("t1_done_drop", {31'd0, done}, 32'd0);
    check("t1_pass_hold", {31'd0, pass}, 32'd1);

    // stuck-at: only the RD1 compare of word 5 fails
    mem_mode = 1;
    start_pulse(32'hA5A5_0000);
    wait_done(1'b0, lat, n_done, d0_5, d1_5, d1_0);
    check("t2_lat", lat, 129);
    check("t2_pass", {31'd0, pass}, 32'd0);
    check("t2_err", {25'd0, err_cnt}, 32'd1);
    check("t2_faddr", {27'd0, fail_addr}, 32'd5);

    // aliasing: reads of 0..15 see words 16..31, both read phases
    mem_mode = 2;
    start_pulse(32'h0);
    check("t3_clear_err", {25'd0, err_cnt}, 32'd0);
    check("t3_clear_faddr", {27'd0, fail_addr}, 32'd0);
    wait_done(1'b0, lat, n_done, d0_5, d1_5, d1_0);
    check("t3_lat", lat, 129);
    check("t3_pass", {31'd0, pass}, 32'd0);
    check("t3_err", {25'd0, err_cnt}, 32'd32);
    check("t3_faddr", {27'd0, fail_addr}, 32'd0);

    // reset mid-run during RD0 at addr 10
    mem_mode = 0;
    start_pulse(32'h1234_5678);
    repeat (42) @(posedge clk);
    #1;
    check("t4_pre_addr", {27'd0, addr}, 32'd10);
    check("t4_pre_wen", {31'd0, wen}, 32'd0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("t4_cen", {31'd0, cen}, 32'd0);
    check("t4_addr", {27'd0, addr}, 32'd0);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_err", {25'd0, err_cnt}, 32'd0);
    n_done = 0;
    for (int i = 0; i < 140; i++) begin
      @(posedge clk);
      #1;
      if (done || busy || cen) n_done++;
    end
    check("t4_quiet", n_done, 0);
    start_pulse(32'h1234_5678);
    wait_done(1'b0, lat, n_done, d0_5, d1_5, d1_0);
    check("t4_lat", lat, 129);
    check("t4_pass", {31'd0, pass}, 32'd1);

    // start re-pulsed at edges 40 and 129; start at edge 130 accepted
    start_pulse(32'h0F0F_F0F0);
    wait_done(1'b1, lat, n_done, d0_5, d1_5, d1_0);
    check("t5_lat", lat, 129);
    check("t5_ndone", n_done, 1);
    check("t5_pass", {31'd0, pass}, 32'd1);
    // start is still 1 here: edge 130 samples it
    seed = 32'h0F0F_F0F0;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("t5_done_drop", {31'd0, done}, 32'd0);
    check("t5_restart_busy", {31'd0, busy}, 32'd1);
    check("t5_restart_din", din, 32'h0F0F_F0F0);
    wait_done(1'b0, lat, n_done, d0_5, d1_5, d1_0);
    check("t5_lat2", lat, 129);
    check("t5_pass2", {31'd0, pass}, 32'd1);

    // back-to-back: first run fails (word 5 in RD0), second run is clean
    mem_mode = 1;
    start_pulse(32'hFFFF_FFFF);
    wait_done(1'b0, lat, n_done, d0_5, d1_5, d1_0);
    check("t6a_lat", lat, 129);
    check("t6a_err", {25'd0, err_cnt}, 32'd1);
    check("t6a_faddr", {27'd0, fail_addr}, 32'd5);
    check("t6a_wr1_0", d1_0, 32'h0000_0000);
    mem_mode = 0;
    start_pulse(32'h0);
    check("t6b_clear_err", {25'd0, err_cnt}, 32'd0);
    check("t6b_clear_faddr", {27'd0, fail_addr}, 32'd0);
    check("t6b_clear_pass", {31'd0, pass}, 32'd0);
    wait_done(1'b0, lat, n_done, d0_5, d1_5, d1_0);
    check("t6b_lat", lat, 129);
    check("t6b_wr1_0", d1_0, 32'hFFFF_FFFF);
    check("t6b_wr0_5", d0_5, 32'h0000_0005);
    check("t6b_pass", {31'd0, pass}, 32'd1);
    check("t6b_err", {25'd0, err_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bist.md
# mem_bist

Built-in self-test initiator for the 32 x 32-bit synchronous single-port memory: drives its `cen`/`wen`/`addr`/`din` port and checks its `dout`. On `start` it runs a four-phase march:
- write a seed-derived pattern;
- read and compare;
- write the inverted pattern;
- read and compare.

It reports pass/fail, error count and first failing address. It sits between the lab top level and the memory instance, replacing the hand-driven stimulus path.

## Interface
Parameters:
- `AW`, 5, address width (depth = 2^AW = 32)
- `DW`, 32, data width

Ports:
- `clk`  in  1  single system clock, rising-edge
- `reset_n`  in  1  synchronous, active-low reset
- `start`  in  1  begin test; sampled only in IDLE
- `seed`  in  DW  pattern seed; captured when start is accepted
- `cen`  out  1  memory chip enable
- `wen`  out  1  memory write enable (1 = write, 0 = read)
- `addr`  out  AW  memory address
- `din`  out  DW  memory write data
- `dout`  in  DW  memory read data; combinational from `addr` while cen=1, wen=0
- `busy`  out  1  test in progress
- `done`  out  1  one-cycle pulse at test end
- `pass`  out  1  last test had zero errors; held until next start
- `err_cnt`  out  7  mismatches in last test (0..64)
- `fail_addr`  out  AW  address of first mismatch; 0 if none

## Operation
- Data patterns:
  - P0(a) = seed_q ^ zero-extended a.
  - P1(a) = ~P0(a).
  - seed_q is captured at start acceptance.
- FSM states: IDLE -> WR0 -> RD0 -> WR1 -> RD1 -> FIN -> IDLE.
- IDLE:
  - cen=0, wen=0, addr=0, din=0.
  - start=1 -> WR0 with addr=0.
  - On acceptance: err_cnt, fail_addr and pass clear, first-fail flag clears, seed_q <= seed.
- WR0/WR1: cen=1, wen=1, din=P0/P1(addr). addr increments each cycle.
- RD0/RD1:
  - cen=1, wen=0.
  - Each edge compares dout against P0/P1(addr).
  - Mismatch: err_cnt+1. If it is the first mismatch of the test, fail_addr <= addr and the first-fail flag is set.
- Phase end: addr==31 in any phase -> next phase, addr wraps to 0. RD1 at addr 31 -> FIN.
- FIN: cen=0. Next edge: done=1, pass <= (err_cnt==0), state -> IDLE.
- start while not IDLE: ignored; no restart, no queueing.
- err_cnt never exceeds 64 (at most 64 compares), so no saturation logic is needed.

## Timing
- All outputs are registered.
- Reset values: cen=0, wen=0, addr=0, din=0, busy=0, done=0, pass=0, err_cnt=0, fail_addr=0; state=IDLE.
- Edge numbering: edge 0 is the edge sampling start=1 in IDLE.
- After edge 0: cen=1, wen=1, addr=0, din=P0(0), busy=1.
- Edges 1..32: writes addr 0..31. After edge 32: RD0, addr=0, wen=0.
- Edges 33..64: compares addr 0..31. After edge 64: WR1.
- Edges 65..96: writes P1. After edge 96: RD1.
- Edges 97..128: compares. After edge 128: FIN, cen=0.
- Edge 129: done=1, busy=0, pass valid.
- Edge 130: done=0.
- Start-to-done latency is 129 cycles. A new start is accepted at edge 130 at the earliest.
- Reset mid-test (reset_n=0 at any edge):
  - Next cycle: all outputs take reset values.
  - The memory sees cen=0; no partial write occurs after that edge.
- Simultaneous mismatch and phase change at addr 31: the count is updated and the phase advances on the same edge.

## Test plan
- Ideal memory, seed=32'hA5A5_0000, start pulse:
  - din at addr 5 in WR0 = 32'hA5A5_0005; in WR1 = 32'h5A5A_FFFA.
  - done 129 cycles after start; pass=1, err_cnt=0, fail_addr=0.
- Memory model with word 5 bit 3 stuck at 0, same seed:
  - RD0 passes (P0 bit 3 = 0).
  - RD1 fails, then done with err_cnt=1, fail_addr=5, pass=0.
- Memory model ignoring addr[4] (aliasing), seed=0:
  - Reads of addr 0..15 return data for addr 16..31 in both read phases.
  - err_cnt=32, fail_addr=0, pass=0.
- Reset mid-run: reset_n=0 for one edge during RD0 at addr 10.
  - Next cycle: cen=0, addr=0, busy=0, err_cnt=0; no done pulse.
  - A subsequent start completes with pass=1 at 129 cycles.
- Start re-pulsed at edge 40 and at edge 129 of a run:
  - Both are ignored; done occurs exactly once at edge 129.
  - A start at edge 130 is accepted.
- Back-to-back runs, seed 32'hFFFF_FFFF then 32'h0:
  - The second run clears err_cnt/fail_addr at acceptance.
  - WR1 din at addr 0 = 32'hFFFF_FFFF in the second run.
